// File: rtl/red_pitaya_decimator_block_if.sv
// rtl/red_pitaya_decimator_block_if.sv - sample input / decimated output bundle for the boxcar decimator
// min_o/max_o exist only when DECIM_PEAK_EN is defined.
interface red_pitaya_decimator_block_if #(
  parameter int SIGNALBITS  = 14,
  parameter int LOG2DECBITS = 4
);
  logic                          enable_i;
  logic                          sync_i;
  logic        [LOG2DECBITS-1:0] log2dec_i;
  logic signed [SIGNALBITS-1:0]  signal_i;
  logic signed [SIGNALBITS-1:0]  signal_o;
  logic                          valid_o;
`ifdef DECIM_PEAK_EN
  logic signed [SIGNALBITS-1:0]  min_o;
  logic signed [SIGNALBITS-1:0]  max_o;

  modport master (
    output enable_i, sync_i, log2dec_i, signal_i,
    input  signal_o, valid_o, min_o, max_o
  );
  modport slave (
    input  enable_i, sync_i, log2dec_i, signal_i,
    output signal_o, valid_o, min_o, max_o
  );
`else
  modport master (
    output enable_i, sync_i, log2dec_i, signal_i,
    input  signal_o, valid_o
  );
  modport slave (
    input  enable_i, sync_i, log2dec_i, signal_i,
    output signal_o, valid_o
  );
`endif
endinterface

// File: rtl/red_pitaya_decimator_block.sv
// rtl/red_pitaya_decimator_block.sv - boxcar-averaging decimator, mean of 2^n samples per window
// Optional DECIM_PEAK_EN adds per-window min/max outputs.
module red_pitaya_decimator_block #(
  parameter int SIGNALBITS  = 14,
  parameter int LOG2DECBITS = 4,
  parameter int MAXLOG2DEC  = 13
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  red_pitaya_decimator_block_if.slave bus
);
  localparam int ACCW = SIGNALBITS + MAXLOG2DEC;
  localparam int CNTW = MAXLOG2DEC;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  state_q;
  logic [LOG2DECBITS-1:0]  n_d, n_q;
  logic signed [ACCW-1:0]  acc_q, acc_base, sum;
  logic [CNTW-1:0]         cnt_q, cnt_base, cnt_last;
  logic                    restart, last;
  logic signed [SIGNALBITS-1:0] signal_q;
  logic                    valid_q;

  // A restart makes the current sample sample 0 of a fresh window.
  always_comb begin
    n_d      = (bus.log2dec_i > LOG2DECBITS'(MAXLOG2DEC)) ? LOG2DECBITS'(MAXLOG2DEC) : bus.log2dec_i;
    restart  = (state_q == IDLE) || bus.sync_i || (n_d != n_q);
    acc_base = restart ? '0 : acc_q;
    cnt_base = restart ? '0 : cnt_q;
    cnt_last = CNTW'((32'd1 << n_d) - 32'd1);
    last     = (cnt_base == cnt_last);
    sum      = acc_base + $signed({{MAXLOG2DEC{bus.signal_i[SIGNALBITS-1]}}, bus.signal_i});
  end

`ifdef DECIM_PEAK_EN
  logic signed [SIGNALBITS-1:0] run_min_q, run_max_q, min_d, max_d, min_q, max_q;
  logic                         seed;

  always_comb begin
    seed  = (cnt_base == '0);
    min_d = (seed || (bus.signal_i < run_min_q)) ? bus.signal_i : run_min_q;
    max_d = (seed || (bus.signal_i > run_max_q)) ? bus.signal_i : run_max_q;
  end

  assign bus.min_o = min_q;
  assign bus.max_o = max_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      n_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      signal_q  <= '0;
      valid_q   <= 1'b0;
`ifdef DECIM_PEAK_EN
      run_min_q <= '0;
      run_max_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
`endif
    end else begin
      n_q <= n_d;
      if (!bus.enable_i) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
`ifdef DECIM_PEAK_EN
        run_min_q <= '0;
        run_max_q <= '0;
`endif
      end else begin
        state_q <= ACC;
`ifdef DECIM_PEAK_EN
        run_min_q <= min_d;
        run_max_q <= max_d;
`endif
        if (last) begin
          signal_q <= SIGNALBITS'(sum >>> n_d);
          valid_q  <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
`ifdef DECIM_PEAK_EN
          min_q    <= min_d;
          max_q    <= max_d;
`endif
        end else begin
          acc_q   <= sum;
          cnt_q   <= cnt_base + CNTW'(1);
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.signal_o = signal_q;
  assign bus.valid_o  = valid_q;
endmodule

// File: tb/tb_red_pitaya_decimator_block.sv
// tb/tb_red_pitaya_decimator_block.sv - self-checking bench for red_pitaya_decimator_block
// Build with DECIM_PEAK_EN defined to also check min_o/max_o.
module tb_red_pitaya_decimator_block;
  logic clk  = 1'b0;
  logic rstn = 1'b0;

  red_pitaya_decimator_block_if #(.SIGNALBITS(14), .LOG2DECBITS(4)) bus ();

  red_pitaya_decimator_block #(.SIGNALBITS(14), .LOG2DECBITS(4), .MAXLOG2DEC(13)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic en; logic sy; int l2d; int x;
    logic ev; int es; int emn; int emx;
  } vec_t;

  typedef struct { logic v; int s; int mn; int mx; } exp_t;

  vec_t   tbl [12];
  exp_t   sb [$];
  int     n_vec = 0;
  int     n_bad = 0;

  logic   m_active;
  int     m_nq, m_cnt, m_out, m_min, m_max, m_omin, m_omax;
  longint m_sum;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_nq = 0; m_cnt = 0; m_sum = 0;
    m_out = 0; m_min = 0; m_max = 0; m_omin = 0; m_omax = 0;
  endtask

  task automatic model_step(input logic en, input logic sy, input int l2d, input int x, output exp_t e);
    int     n;
    longint d, q;
    n = (l2d > 13) ? 13 : l2d;
    e.v = 1'b0;
    if (!en) begin
      m_active = 1'b0; m_cnt = 0; m_sum = 0;
    end else begin
      if (!m_active || sy || n != m_nq) begin
        m_cnt = 0; m_sum = 0;
      end
      m_active = 1'b1;
      if (m_cnt == 0) begin m_min = x; m_max = x; end
      else begin
        if (x < m_min) m_min = x;
        if (x > m_max) m_max = x;
      end
      m_sum += x;
      m_cnt++;
      if (m_cnt == (1 << n)) begin
        d = longint'(1) << n;
        q = m_sum / d;
        if ((m_sum % d) != 0 && m_sum < 0) q = q - 1;
        m_out = int'(q); m_omin = m_min; m_omax = m_max;
        e.v = 1'b1; m_cnt = 0; m_sum = 0;
      end
    end
    m_nq = n;
    e.s = m_out; e.mn = m_omin; e.mx = m_omax;
  endtask

  task automatic step(input logic en, input logic sy, input int l2d, input int x);
    exp_t e, got;
    bus.enable_i  = en;
    bus.sync_i    = sy;
    bus.log2dec_i = 4'(l2d);
    bus.signal_i  = 14'(x);
    model_step(en, sy, l2d, x, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("valid_o", {31'd0, bus.valid_o}, {31'd0, got.v});
    check("signal_o", 32'(bus.signal_o), got.s);
`ifdef DECIM_PEAK_EN
    check("min_o", 32'(bus.min_o), got.mn);
    check("max_o", 32'(bus.max_o), got.mx);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, " signal_o"}, 32'(bus.signal_o), 0);
    check({tag, " valid_o"}, {31'd0, bus.valid_o}, 0);
`ifdef DECIM_PEAK_EN
    check({tag, " min_o"}, 32'(bus.min_o), 0);
    check({tag, " max_o"}, 32'(bus.max_o), 0);
`endif
  endtask

  function automatic int rnd14();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    // n=2 windows: {0,1,2,3} -> 1, {-1,-1,-1,-2} -> floor(-1.25) = -2, {5,-7,3,9} -> 2
    tbl[0]  = '{1'b1, 1'b0, 2,  0, 1'b0,  0,  0, 0};
    tbl[1]  = '{1'b1, 1'b0, 2,  1, 1'b0,  0,  0, 0};
    tbl[2]  = '{1'b1, 1'b0, 2,  2, 1'b0,  0,  0, 0};
    tbl[3]  = '{1'b1, 1'b0, 2,  3, 1'b1,  1,  0, 3};
    tbl[4]  = '{1'b1, 1'b0, 2, -1, 1'b0,  1,  0, 3};
    tbl[5]  = '{1'b1, 1'b0, 2, -1, 1'b0,  1,  0, 3};
    tbl[6]  = '{1'b1, 1'b0, 2, -1, 1'b0,  1,  0, 3};
    tbl[7]  = '{1'b1, 1'b0, 2, -2, 1'b1, -2, -2, -1};
    tbl[8]  = '{1'b1, 1'b0, 2,  5, 1'b0, -2, -2, -1};
    tbl[9]  = '{1'b1, 1'b0, 2, -7, 1'b0, -2, -2, -1};
    tbl[10] = '{1'b1, 1'b0, 2,  3, 1'b0, -2, -2, -1};
    tbl[11] = '{1'b1, 1'b0, 2,  9, 1'b1,  2, -7, 9};

    bus.enable_i = 1'b0; bus.sync_i = 1'b0; bus.log2dec_i = '0; bus.signal_i = '0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset held");
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].sy, tbl[i].l2d, tbl[i].x);
      check($sformatf("tbl[%0d] valid_o", i), {31'd0, bus.valid_o}, {31'd0, tbl[i].ev});
      check($sformatf("tbl[%0d] signal_o", i), 32'(bus.signal_o), tbl[i].es);
`ifdef DECIM_PEAK_EN
      check($sformatf("tbl[%0d] min_o", i), 32'(bus.min_o), tbl[i].emn);
      check($sformatf("tbl[%0d] max_o", i), 32'(bus.max_o), tbl[i].emx);
`endif
    end

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2, 100);

    for (int i = 0; i < 8192; i++) step(1'b1, 1'b0, 13, 8191);
    check("n13 pos mean", 32'(bus.signal_o), 8191);
    for (int i = 0; i < 8192; i++) step(1'b1, 1'b0, 13, -8192);
    check("n13 neg mean", 32'(bus.signal_o), -8192);

    // sync on the 5th sample, then sync landing on a last sample
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3, rnd14());
    step(1'b1, 1'b1, 3, rnd14());
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3, rnd14());
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3, rnd14());
    step(1'b1, 1'b1, 3, rnd14());
    check("sync on last", {31'd0, bus.valid_o}, 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 3, rnd14());

    // log2dec change mid-window, then disable with sync asserted
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, rnd14());
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1, rnd14());
    step(1'b1, 1'b0, 3, rnd14());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, rnd14());
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3, rnd14());

    // reset mid-window with enable held
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2, 1000);
    rstn = 1'b0;
    #1;
    check_zero("mid reset");
    @(posedge clk);
    #1;
    check_zero("mid reset held");
    model_reset();
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 2, rnd14());

    for (int i = 0; i < 8200; i++) step(1'b1, 1'b0, 15, rnd14());

    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, rnd14());
    for (int i = 0; i < 12; i++) step(($urandom_range(0, 3) != 0), 1'b0, 1, rnd14());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
